// File: rtl/ns_arb_2to1_if.sv
// One 4-phase req/ack message channel: src/dst/dat qualified by req, returned ack.
// master drives the message, slave returns ack.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

interface ns_arb_2to1_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE
);
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic           req;
    logic           ack;

    modport master (output src, output dst, output dat, output req, input ack);
    modport slave  (input src, input dst, input dat, input req, output ack);
endinterface

// File: rtl/ns_arb_2to1.sv
// Two-input round-robin merge for 4-phase message channels with a one-message buffer.
// Every output is registered, so no input reaches an output combinationally.
//
// state      | meaning
// ST_IDLE    | buffer empty, arbitrating between eligible inputs
// ST_SEND    | buffered message presented, o0.req high
// ST_RELEASE | o0.req dropped, waiting for o0.ack to fall
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module ns_arb_2to1 #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int CSZ = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    ns_arb_2to1_if.slave    i0,
    ns_arb_2to1_if.slave    i1,
    ns_arb_2to1_if.master   o0,
    output logic [1:0]      o_gnt,
    output logic [CSZ-1:0]  o_cnt_0,
    output logic [CSZ-1:0]  o_cnt_1,
    output logic            o_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RELEASE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last;
    logic [ASZ-1:0] src_r;
    logic [ASZ-1:0] dst_r;
    logic [DSZ-1:0] dat_r;
    logic           req_r;
    logic           req_nxt;
    logic [1:0]     gnt_nxt;
    logic           ack0;
    logic           ack1;
    logic           req0_q;
    logic           req1_q;
    logic           elig0;
    logic           elig1;
    logic           take0;
    logic           take1;
    logic           err_now;

    always_comb begin
        state_nxt = state;
        req_nxt   = req_r;
        gnt_nxt   = o_gnt;
        take0     = 1'b0;
        take1     = 1'b0;
        elig0     = i0.req & ~ack0;
        elig1     = i1.req & ~ack1;
        case (state)
            ST_IDLE: begin
                // on a tie the input that was not served last wins
                take0 = elig0 & (~elig1 | last);
                take1 = elig1 & ~take0;
                if (take0 || take1) begin
                    state_nxt = ST_SEND;
                    req_nxt   = 1'b1;
                    gnt_nxt   = {take1, take0};
                end
            end
            ST_SEND: begin
                if (o0.ack) begin
                    state_nxt = ST_RELEASE;
                    req_nxt   = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!o0.ack) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = 2'b00;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
                gnt_nxt   = 2'b00;
            end
        endcase
        // a granted source withdrawing an un-acked request is a protocol violation
        err_now = ((state == ST_IDLE) & o0.ack)
                | (req0_q & ~i0.req & ~ack0 & o_gnt[0])
                | (req1_q & ~i1.req & ~ack1 & o_gnt[1]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            last    <= 1'b1;
            src_r   <= '0;
            dst_r   <= '0;
            dat_r   <= '0;
            req_r   <= 1'b0;
            o_gnt   <= 2'b00;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            req0_q  <= 1'b0;
            req1_q  <= 1'b0;
            o_cnt_0 <= '0;
            o_cnt_1 <= '0;
            o_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_r  <= req_nxt;
            o_gnt  <= gnt_nxt;
            if (take0) begin
                src_r <= i0.src;
                dst_r <= i0.dst;
                dat_r <= i0.dat;
                last  <= 1'b0;
            end else if (take1) begin
                src_r <= i1.src;
                dst_r <= i1.dst;
                dat_r <= i1.dat;
                last  <= 1'b1;
            end
            // ack rises on grant and falls on the first edge that sees req low
            ack0    <= take0 | (ack0 & i0.req);
            ack1    <= take1 | (ack1 & i1.req);
            req0_q  <= i0.req;
            req1_q  <= i1.req;
            o_cnt_0 <= o_cnt_0 + CSZ'(take0);
            o_cnt_1 <= o_cnt_1 + CSZ'(take1);
            o_err   <= o_err | err_now;
        end
    end

    assign o0.src = src_r;
    assign o0.dst = dst_r;
    assign o0.dat = dat_r;
    assign o0.req = req_r;
    assign i0.ack = ack0;
    assign i1.ack = ack1;

endmodule
